lsu_align: RTL and testbench

Parametrised load/store alignment unit between the MEM-stage address/data and the word-organised data memory or device bus. It generalises the fixed 32-bit byte-enable and load-extraction path to any power-of-two data width. It adds a request/response handshake, bus back-pressure, and optional split handling of accesses that cross a word boundary. Each access runs as a small FSM issuing one or two bus beats, then returns the aligned and extended load word or a store completion.

---
 rtl/lsu_pkg.sv | 21 ++
 rtl/lsu_lane_shift.sv | 53 +++++
 rtl/lsu_align.sv | 228 ++++++++++++++++++++++
 tb/tb_lsu_align.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store alignment unit.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2,
        RESP  = 2'd3
    } lsu_state_e;

    localparam int unsigned SZ_B = 0;
    localparam int unsigned SZ_H = 1;
    localparam int unsigned SZ_W = 2;
    localparam int unsigned SZ_D = 3;

    // Width of req_size: enough bits to encode log2 access sizes 0..OFF_W.
    function automatic int unsigned calc_size_w(input int unsigned data_w);
        return $clog2($clog2(data_w / 8) + 1);
    endfunction

endpackage

// File: rtl/lsu_lane_shift.sv
// Combinational lane steering: store data/byte-enable placement across two
// bus words, and load extraction with zero/sign extension.
module lsu_lane_shift
    import lsu_pkg::*;
#(
    parameter  int unsigned DATA_W = 32,
    localparam int unsigned BYTES  = DATA_W / 8,
    localparam int unsigned OFF_W  = $clog2(BYTES),
    localparam int unsigned SIZE_W = calc_size_w(DATA_W)
) (
    input  logic [OFF_W-1:0]    off,
    input  logic [SIZE_W-1:0]   size,
    input  logic                sign_ext,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [2*DATA_W-1:0] rbuf,
    output logic [2*DATA_W-1:0] lane_data_c,
    output logic [2*BYTES-1:0]  lane_be_c,
    output logic [DATA_W-1:0]   load_data_c
);

    int unsigned       nbytes;
    logic [DATA_W-1:0] shifted;
    logic              sign_bit;

    // Oversized requests are rejected upstream; clamp keeps the lane logic bounded.
    always_comb begin
        nbytes = 32'(1) << size;
        if (nbytes > BYTES) begin
            nbytes = BYTES;
        end
    end

    always_comb begin
        lane_data_c = {{DATA_W{1'b0}}, wdata} << {off, 3'b000};
        for (int unsigned i = 0; i < 2 * BYTES; i++) begin
            lane_be_c[i] = (i >= 32'(off)) && (i < 32'(off) + nbytes);
        end
    end

    always_comb begin
        shifted  = DATA_W'(rbuf >> {off, 3'b000});
        sign_bit = 1'b0;
        for (int unsigned b = 0; b < BYTES; b++) begin
            if (b + 1 == nbytes) begin
                sign_bit = sign_ext & shifted[8*b+7];
            end
        end
        for (int unsigned b = 0; b < BYTES; b++) begin
            load_data_c[8*b +: 8] = (b < nbytes) ? shifted[8*b +: 8] : {8{sign_bit}};
        end
    end

endmodule

// File: rtl/lsu_align.sv
// Load/store alignment unit: accepts one request, issues one or two word
// beats on the bus, then returns an aligned/extended load or store completion.
module lsu_align
    import lsu_pkg::*;
#(
    parameter  int unsigned DATA_W           = 32,
    parameter  int unsigned ADDR_W           = 32,
    parameter  bit          ALLOW_MISALIGNED = 1'b1,
    localparam int unsigned BYTES            = DATA_W / 8,
    localparam int unsigned OFF_W            = $clog2(BYTES),
    localparam int unsigned SIZE_W           = calc_size_w(DATA_W)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [SIZE_W-1:0] req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              bus_valid,
    input  logic              bus_ready,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [BYTES-1:0]  bus_be,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err
);

    lsu_state_e state_q, state_d;

    logic              we_q,     we_d;
    logic [SIZE_W-1:0] size_q,   size_d;
    logic              sgn_q,    sgn_d;
    logic [ADDR_W-1:0] addr_q,   addr_d;
    logic [DATA_W-1:0] wdata_q,  wdata_d;
    logic              split_q,  split_d;
    logic              err_q,    err_d;
    logic [DATA_W-1:0] buf_lo_q, buf_lo_d;
    logic [DATA_W-1:0] buf_hi_q, buf_hi_d;

    logic              req_ready_q, req_ready_d;
    logic              bus_valid_q, bus_valid_d;
    logic              bus_we_q,    bus_we_d;
    logic [ADDR_W-1:0] bus_addr_q,  bus_addr_d;
    logic [BYTES-1:0]  bus_be_q,    bus_be_d;
    logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q,  rsp_data_d;
    logic              rsp_err_q,   rsp_err_d;

    logic                accept_c;
    logic [OFF_W-1:0]    req_off_c;
    int unsigned         req_nbytes_c;
    logic                req_split_c;
    logic                req_err_c;
    logic [2*DATA_W-1:0] rbuf_c;
    logic [2*DATA_W-1:0] lane_data_c;
    logic [2*BYTES-1:0]  lane_be_c;
    logic [DATA_W-1:0]   load_data_c;
    logic [ADDR_W-1:0]   word_addr_c;

    // Classify the incoming request before it is latched.
    always_comb begin
        accept_c     = (state_q == IDLE) && req_valid;
        req_off_c    = req_addr[OFF_W-1:0];
        req_nbytes_c = 32'(1) << req_size;
        req_split_c  = (32'(req_off_c) + req_nbytes_c) > BYTES;
        req_err_c    = (32'(req_size) > OFF_W) || (req_split_c && !ALLOW_MISALIGNED);
    end

    // Request latch; the _d view is what the bus beat being set up will use.
    always_comb begin
        we_d    = we_q;
        size_d  = size_q;
        sgn_d   = sgn_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        split_d = split_q;
        err_d   = err_q;
        if (accept_c) begin
            we_d    = req_we;
            size_d  = req_size;
            sgn_d   = req_signed;
            addr_d  = req_addr;
            wdata_d = req_wdata;
            split_d = req_split_c;
            err_d   = req_err_c;
        end
    end

    // Read capture; rbuf_c includes the beat completing this cycle.
    always_comb begin
        buf_lo_d = buf_lo_q;
        buf_hi_d = buf_hi_q;
        rbuf_c   = {buf_hi_q, buf_lo_q};
        if (bus_valid_q && bus_ready && !bus_we_q) begin
            if (state_q == BEAT0) begin
                buf_lo_d                = bus_rdata;
                rbuf_c[DATA_W-1:0]      = bus_rdata;
            end else if (state_q == BEAT1) begin
                buf_hi_d                = bus_rdata;
                rbuf_c[2*DATA_W-1:DATA_W] = bus_rdata;
            end
        end
    end

    lsu_lane_shift #(
        .DATA_W (DATA_W)
    ) u_lane_shift (
        .off         (addr_d[OFF_W-1:0]),
        .size        (size_d),
        .sign_ext    (sgn_d),
        .wdata       (wdata_d),
        .rbuf        (rbuf_c),
        .lane_data_c (lane_data_c),
        .lane_be_c   (lane_be_c),
        .load_data_c (load_data_c)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (req_valid) state_d = req_err_c ? RESP : BEAT0;
            BEAT0: if (bus_ready) state_d = split_q ? BEAT1 : RESP;
            BEAT1: if (bus_ready) state_d = RESP;
            RESP:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_comb begin
        word_addr_c = addr_d & ~ADDR_W'(BYTES - 1);
        req_ready_d = (state_d == IDLE);
        bus_valid_d = 1'b0;
        bus_we_d    = 1'b0;
        bus_addr_d  = '0;
        bus_be_d    = '0;
        bus_wdata_d = '0;
        rsp_valid_d = 1'b0;
        rsp_data_d  = '0;
        rsp_err_d   = 1'b0;
        case (state_d)
            BEAT0: begin
                bus_valid_d = 1'b1;
                bus_we_d    = we_d;
                bus_addr_d  = word_addr_c;
                bus_be_d    = we_d ? lane_be_c[BYTES-1:0] : '1;
                bus_wdata_d = we_d ? lane_data_c[DATA_W-1:0] : '0;
            end
            BEAT1: begin
                bus_valid_d = 1'b1;
                bus_we_d    = we_d;
                bus_addr_d  = ADDR_W'(word_addr_c + ADDR_W'(BYTES));
                bus_be_d    = we_d ? lane_be_c[2*BYTES-1:BYTES] : '1;
                bus_wdata_d = we_d ? lane_data_c[2*DATA_W-1:DATA_W] : '0;
            end
            RESP: begin
                rsp_valid_d = 1'b1;
                rsp_err_d   = err_d;
                if (!err_d && !we_d) begin
                    rsp_data_d = load_data_c;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            size_q      <= '0;
            sgn_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            split_q     <= 1'b0;
            err_q       <= 1'b0;
            buf_lo_q    <= '0;
            buf_hi_q    <= '0;
            req_ready_q <= 1'b1;
            bus_valid_q <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_be_q    <= '0;
            bus_wdata_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            size_q      <= size_d;
            sgn_q       <= sgn_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            split_q     <= split_d;
            err_q       <= err_d;
            buf_lo_q    <= buf_lo_d;
            buf_hi_q    <= buf_hi_d;
            req_ready_q <= req_ready_d;
            bus_valid_q <= bus_valid_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_be_q    <= bus_be_d;
            bus_wdata_q <= bus_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign req_ready = req_ready_q;
    assign bus_valid = bus_valid_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_be    = bus_be_q;
    assign bus_wdata = bus_wdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_lsu_align.sv
// Directed bench for lsu_align: 32-bit split-capable, 32-bit strict-alignment
// and 64-bit instances driven from one clock.
module tb_lsu_align;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // Instance A: DATA_W 32, misaligned accesses split.
    logic        a_req_valid, a_req_ready, a_req_we, a_req_signed;
    logic [1:0]  a_req_size;
    logic [31:0] a_req_addr, a_req_wdata;
    logic        a_bus_valid, a_bus_ready, a_bus_we;
    logic [31:0] a_bus_addr, a_bus_wdata, a_bus_rdata;
    logic [3:0]  a_bus_be;
    logic        a_rsp_valid, a_rsp_err;
    logic [31:0] a_rsp_data;

    // Instance E: DATA_W 32, misaligned accesses rejected.
    logic        e_req_valid, e_req_ready, e_req_we, e_req_signed;
    logic [1:0]  e_req_size;
    logic [31:0] e_req_addr, e_req_wdata;
    logic        e_bus_valid, e_bus_ready, e_bus_we;
    logic [31:0] e_bus_addr, e_bus_wdata, e_bus_rdata;
    logic [3:0]  e_bus_be;
    logic        e_rsp_valid, e_rsp_err;
    logic [31:0] e_rsp_data;

    // Instance D: DATA_W 64.
    logic        d_req_valid, d_req_ready, d_req_we, d_req_signed;
    logic [1:0]  d_req_size;
    logic [31:0] d_req_addr;
    logic [63:0] d_req_wdata;
    logic        d_bus_valid, d_bus_ready, d_bus_we;
    logic [31:0] d_bus_addr;
    logic [63:0] d_bus_wdata, d_bus_rdata;
    logic [7:0]  d_bus_be;
    logic        d_rsp_valid, d_rsp_err;
    logic [63:0] d_rsp_data;

    lsu_align #(.DATA_W(32), .ADDR_W(32), .ALLOW_MISALIGNED(1'b1)) u_dut_a (
        .clk(clk), .reset(reset),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
        .req_size(a_req_size), .req_signed(a_req_signed), .req_addr(a_req_addr),
        .req_wdata(a_req_wdata), .bus_valid(a_bus_valid), .bus_ready(a_bus_ready),
        .bus_we(a_bus_we), .bus_addr(a_bus_addr), .bus_be(a_bus_be),
        .bus_wdata(a_bus_wdata), .bus_rdata(a_bus_rdata), .rsp_valid(a_rsp_valid),
        .rsp_data(a_rsp_data), .rsp_err(a_rsp_err)
    );

    lsu_align #(.DATA_W(32), .ADDR_W(32), .ALLOW_MISALIGNED(1'b0)) u_dut_e (
        .clk(clk), .reset(reset),
        .req_valid(e_req_valid), .req_ready(e_req_ready), .req_we(e_req_we),
        .req_size(e_req_size), .req_signed(e_req_signed), .req_addr(e_req_addr),
        .req_wdata(e_req_wdata), .bus_valid(e_bus_valid), .bus_ready(e_bus_ready),
        .bus_we(e_bus_we), .bus_addr(e_bus_addr), .bus_be(e_bus_be),
        .bus_wdata(e_bus_wdata), .bus_rdata(e_bus_rdata), .rsp_valid(e_rsp_valid),
        .rsp_data(e_rsp_data), .rsp_err(e_rsp_err)
    );

    lsu_align #(.DATA_W(64), .ADDR_W(32), .ALLOW_MISALIGNED(1'b1)) u_dut_d (
        .clk(clk), .reset(reset),
        .req_valid(d_req_valid), .req_ready(d_req_ready), .req_we(d_req_we),
        .req_size(d_req_size), .req_signed(d_req_signed), .req_addr(d_req_addr),
        .req_wdata(d_req_wdata), .bus_valid(d_bus_valid), .bus_ready(d_bus_ready),
        .bus_we(d_bus_we), .bus_addr(d_bus_addr), .bus_be(d_bus_be),
        .bus_wdata(d_bus_wdata), .bus_rdata(d_bus_rdata), .rsp_valid(d_rsp_valid),
        .rsp_data(d_rsp_data), .rsp_err(d_rsp_err)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic e_bus_seen = 1'b0;

    always @(posedge clk) begin
        if (e_bus_valid) e_bus_seen <= 1'b1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request to A and return in the cycle after the accepting edge.
    task automatic a_issue(input logic we, input logic [1:0] size, input logic sgn,
                           input logic [31:0] addr, input logic [31:0] wdata);
        int waited;
        waited       = 0;
        a_req_we     = we;
        a_req_size   = size;
        a_req_signed = sgn;
        a_req_addr   = addr;
        a_req_wdata  = wdata;
        a_req_valid  = 1'b1;
        while (!a_req_ready && waited < 20) begin
            tick();
            waited++;
        end
        check("a_req_ready_before_accept", 64'(a_req_ready), 64'(1));
        tick();
        a_req_valid = 1'b0;
    endtask

    task automatic e_issue(input logic we, input logic [1:0] size, input logic [31:0] addr);
        e_req_we    = we;
        e_req_size  = size;
        e_req_addr  = addr;
        e_req_valid = 1'b1;
        check("e_req_ready_before_accept", 64'(e_req_ready), 64'(1));
        tick();
        e_req_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int rsp_seen;
        reset = 1'b1;
        a_req_valid = 0; a_req_we = 0; a_req_size = 0; a_req_signed = 0;
        a_req_addr = 0; a_req_wdata = 0; a_bus_ready = 1; a_bus_rdata = 0;
        e_req_valid = 0; e_req_we = 0; e_req_size = 0; e_req_signed = 0;
        e_req_addr = 0; e_req_wdata = 0; e_bus_ready = 1; e_bus_rdata = 0;
        d_req_valid = 0; d_req_we = 0; d_req_size = 0; d_req_signed = 0;
        d_req_addr = 0; d_req_wdata = 0; d_bus_ready = 1; d_bus_rdata = 0;
        repeat (3) tick();

        check("rst_req_ready", 64'(a_req_ready), 64'(1));
        check("rst_bus_valid", 64'(a_bus_valid), 64'(0));
        check("rst_bus_we",    64'(a_bus_we),    64'(0));
        check("rst_bus_addr",  64'(a_bus_addr),  64'(0));
        check("rst_bus_be",    64'(a_bus_be),    64'(0));
        check("rst_bus_wdata", 64'(a_bus_wdata), 64'(0));
        check("rst_rsp_valid", 64'(a_rsp_valid), 64'(0));
        check("rst_rsp_data",  64'(a_rsp_data),  64'(0));
        check("rst_rsp_err",   64'(a_rsp_err),   64'(0));
        reset = 1'b0;
        tick();

        // Aligned word load.
        a_bus_rdata = 32'h1122_3344;
        a_issue(1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
        check("ldw_bus_valid", 64'(a_bus_valid), 64'(1));
        check("ldw_bus_we",    64'(a_bus_we),    64'(0));
        check("ldw_bus_addr",  64'(a_bus_addr),  64'h100);
        check("ldw_bus_be",    64'(a_bus_be),    64'hF);
        check("ldw_rsp_early", 64'(a_rsp_valid), 64'(0));
        tick();
        check("ldw_rsp_valid", 64'(a_rsp_valid), 64'(1));
        check("ldw_rsp_data",  64'(a_rsp_data),  64'h1122_3344);
        check("ldw_rsp_err",   64'(a_rsp_err),   64'(0));
        check("ldw_bus_idle",  64'(a_bus_valid), 64'(0));
        tick();
        check("ldw_rsp_pulse", 64'(a_rsp_valid), 64'(0));
        check("ldw_ready_back", 64'(a_req_ready), 64'(1));

        // Byte loads at the top lane, signed then unsigned.
        a_bus_rdata = 32'h80AA_BBCC;
        a_issue(1'b0, 2'd0, 1'b1, 32'h103, 32'h0);
        check("lbs_bus_addr", 64'(a_bus_addr), 64'h100);
        tick();
        check("lbs_rsp_valid", 64'(a_rsp_valid), 64'(1));
        check("lbs_rsp_data",  64'(a_rsp_data),  64'hFFFF_FF80);
        tick();
        a_issue(1'b0, 2'd0, 1'b0, 32'h103, 32'h0);
        tick();
        check("lbu_rsp_data",  64'(a_rsp_data),  64'h0000_0080);
        tick();

        // Half load ending exactly at the word boundary stays single-beat.
        a_bus_rdata = 32'h7FEE_1234;
        a_issue(1'b0, 2'd1, 1'b1, 32'h102, 32'h0);
        tick();
        check("lh_edge_rsp_valid", 64'(a_rsp_valid), 64'(1));
        check("lh_edge_rsp_data",  64'(a_rsp_data),  64'h0000_7FEE);
        tick();

        // Split signed half load.
        a_bus_rdata = 32'hAB00_0000;
        a_issue(1'b0, 2'd1, 1'b1, 32'h103, 32'h0);
        check("lhs_b0_addr", 64'(a_bus_addr), 64'h100);
        tick();
        a_bus_rdata = 32'h0000_00CD;
        check("lhs_b1_valid", 64'(a_bus_valid), 64'(1));
        check("lhs_b1_addr",  64'(a_bus_addr),  64'h104);
        check("lhs_b1_be",    64'(a_bus_be),    64'hF);
        check("lhs_b1_norsp", 64'(a_rsp_valid), 64'(0));
        tick();
        check("lhs_rsp_valid", 64'(a_rsp_valid), 64'(1));
        check("lhs_rsp_data",  64'(a_rsp_data),  64'hFFFF_CDAB);
        tick();

        // Split word store.
        a_issue(1'b1, 2'd2, 1'b0, 32'h102, 32'hDDCC_BBAA);
        check("sw_b0_we",    64'(a_bus_we),    64'(1));
        check("sw_b0_addr",  64'(a_bus_addr),  64'h100);
        check("sw_b0_be",    64'(a_bus_be),    64'b1100);
        check("sw_b0_wdata", 64'(a_bus_wdata), 64'hBBAA_0000);
        tick();
        check("sw_b1_addr",  64'(a_bus_addr),  64'h104);
        check("sw_b1_be",    64'(a_bus_be),    64'b0011);
        check("sw_b1_wdata", 64'(a_bus_wdata), 64'h0000_DDCC);
        tick();
        check("sw_rsp_valid", 64'(a_rsp_valid), 64'(1));
        check("sw_rsp_data",  64'(a_rsp_data),  64'(0));
        check("sw_rsp_err",   64'(a_rsp_err),   64'(0));
        tick();

        // Back-pressure: three stalled cycles on a single-beat load.
        a_bus_ready = 1'b0;
        a_bus_rdata = 32'hDEAD_BEEF;
        a_issue(1'b0, 2'd2, 1'b0, 32'h200, 32'h0);
        check("bp_t1_valid", 64'(a_bus_valid), 64'(1));
        check("bp_t1_addr",  64'(a_bus_addr),  64'h200);
        for (int k = 2; k <= 4; k++) begin
            tick();
            check("bp_hold_valid", 64'(a_bus_valid), 64'(1));
            check("bp_hold_addr",  64'(a_bus_addr),  64'h200);
            check("bp_hold_be",    64'(a_bus_be),    64'hF);
            check("bp_hold_norsp", 64'(a_rsp_valid), 64'(0));
        end
        a_bus_ready = 1'b1;
        a_bus_rdata = 32'h1234_5678;
        tick();
        check("bp_rsp_valid", 64'(a_rsp_valid), 64'(1));
        check("bp_rsp_data",  64'(a_rsp_data),  64'h1234_5678);
        tick();

        // Oversized request on A is an error with no bus beat.
        a_issue(1'b0, 2'd3, 1'b0, 32'h0, 32'h0);
        check("bad_size_rsp_valid", 64'(a_rsp_valid), 64'(1));
        check("bad_size_rsp_err",   64'(a_rsp_err),   64'(1));
        check("bad_size_no_bus",    64'(a_bus_valid), 64'(0));
        tick();

        // Reset during BEAT1 abandons the access.
        a_bus_rdata = 32'h0;
        a_issue(1'b0, 2'd1, 1'b1, 32'h103, 32'h0);
        tick();
        check("rstb1_in_beat1", 64'(a_bus_addr), 64'h104);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rstb1_bus_valid", 64'(a_bus_valid), 64'(0));
        check("rstb1_req_ready", 64'(a_req_ready), 64'(1));
        rsp_seen = 0;
        for (int k = 0; k < 4; k++) begin
            if (a_rsp_valid) rsp_seen++;
            tick();
        end
        check("rstb1_no_rsp", 64'(rsp_seen), 64'(0));

        // Aligned load at the top of the address space.
        a_bus_rdata = 32'hCAFE_F00D;
        a_issue(1'b0, 2'd2, 1'b0, 32'hFFFF_FFFC, 32'h0);
        check("top_bus_addr", 64'(a_bus_addr), 64'hFFFF_FFFC);
        tick();
        check("top_rsp_data", 64'(a_rsp_data), 64'hCAFE_F00D);
        tick();

        // Strict-alignment instance: split half store is rejected.
        e_issue(1'b1, 2'd1, 32'h003);
        check("e_mis_rsp_valid", 64'(e_rsp_valid), 64'(1));
        check("e_mis_rsp_err",   64'(e_rsp_err),   64'(1));
        check("e_mis_rsp_data",  64'(e_rsp_data),  64'(0));
        tick();
        check("e_mis_rsp_pulse", 64'(e_rsp_valid), 64'(0));
        e_issue(1'b0, 2'd3, 32'h000);
        check("e_size_rsp_err", 64'(e_rsp_err), 64'(1));
        tick();

        // 64-bit split dword load wraps the second beat to address 0.
        d_bus_rdata  = 64'h8877_6655_4433_2211;
        d_req_we     = 1'b0;
        d_req_size   = 2'd3;
        d_req_signed = 1'b1;
        d_req_addr   = 32'hFFFF_FFFC;
        d_req_valid  = 1'b1;
        check("d_req_ready", 64'(d_req_ready), 64'(1));
        tick();
        d_req_valid = 1'b0;
        check("d_b0_addr", 64'(d_bus_addr), 64'hFFFF_FFF8);
        check("d_b0_be",   64'(d_bus_be),   64'hFF);
        tick();
        d_bus_rdata = 64'h0000_0000_CCBB_AA99;
        check("d_b1_valid", 64'(d_bus_valid), 64'(1));
        check("d_b1_addr",  64'(d_bus_addr),  64'h0);
        tick();
        check("d_rsp_valid", 64'(d_rsp_valid), 64'(1));
        check("d_rsp_data",  d_rsp_data,       64'hCCBB_AA99_8877_6655);
        tick();

        check("e_bus_never_valid", 64'(e_bus_seen), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
